ets_phase_clkgen: RTL and testbench
===================================

# ets_phase_clkgen

Synthesisable, parametrised phase-offset clock generator for equivalent-time sampling (ETS). From the single system clock it derives a divided reference square wave and an ETS square wave whose phase lag is programmable in whole `clk` cycles. Phase changes use a load/step handshake and take effect only at period boundaries, so the ETS edge never glitches. It sits between the ETS sweep controller and the offset sampler, and replaces the fixed 180-degree simulation model with a controllable one usable in both simulation and hardware.

## Interface

- `PERIOD_CYCLES`, 256: `clk` cycles per output period; even, at least 4.
- `DELAY_WIDTH`, `$clog2(PERIOD_CYCLES)`: width of the phase code.
- `LOCK_PERIODS`, 2: full periods after reset before `locked` asserts; at least 1.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `delay_in`  in  `DELAY_WIDTH`  absolute phase lag, in `clk` cycles, for a load request.
- `load`  in  1  one-cycle request to apply `delay_in`.
- `step_inc`  in  1  one-cycle request for lag +1, modulo `PERIOD_CYCLES`.
- `step_dec`  in  1  one-cycle request for lag -1, modulo `PERIOD_CYCLES`.
- `busy`  out  1  a request is accepted and waiting for the next period boundary.
- `done`  out  1  one-cycle pulse on the cycle the new phase takes effect.
- `phase_out`  out  `DELAY_WIDTH`  currently active lag.
- `ref_clk`  out  1  divided reference square wave.
- `ets_clk`  out  1  phase-lagged square wave.
- `locked`  out  1  outputs are stable after reset.

## Operation

- Phase counter `cnt` counts 0 to `PERIOD_CYCLES`-1 and wraps. A wrap is the edge where `cnt` goes from `PERIOD_CYCLES`-1 to 0. Let HALF = `PERIOD_CYCLES`/2.
- All outputs are registered. After an edge that leaves `cnt` = k and active lag = d:
  - `ref_clk` = (k < HALF).
  - `ets_clk` = (((k - d) mod `PERIOD_CYCLES`) < HALF).
  - The subtraction is done `DELAY_WIDTH`+1 bits wide with explicit modulo; it must be correct for non-power-of-two periods.
- Request acceptance applies only while `busy` = 0. Priority order:
  1. `load`: pending = `delay_in`, clamped to `PERIOD_CYCLES`-1 when larger.
  2. Exactly one of `step_inc` / `step_dec`: pending = d±1 with wrap (`PERIOD_CYCLES`-1 +1 gives 0; 0 -1 gives `PERIOD_CYCLES`-1).
  3. `step_inc` and `step_dec` together, with no `load`: ignored.
- When a request is accepted, `busy` = 1 from the next cycle.
- Requests arriving while `busy` = 1 are dropped silently and produce no `done`.
- Application: at the first wrap strictly after the acceptance edge, d ← pending, `busy` ← 0, `done` ← 1 for one cycle.
  - A request accepted on the same edge as a wrap is applied at the following wrap, one full period later.
  - At the applying edge `ets_clk` already uses the new d.
- `locked`: a wrap counter saturates at `LOCK_PERIODS`. `locked` rises on the edge of the `LOCK_PERIODS`-th wrap after reset, where the first post-reset edge counts as wrap 1. It stays high until reset; phase changes do not drop it.
- Setting d = HALF reproduces the legacy 180-degree behaviour: `ets_clk` = ~`ref_clk`.

## Timing

- Reset values: `cnt` = `PERIOD_CYCLES`-1, d = 0, pending = 0, `busy` = 0, `done` = 0, `phase_out` = 0, `ref_clk` = 0, `ets_clk` = 0, `locked` = 0.
- First edge after reset release is a wrap: `cnt` = 0, `ref_clk` = 1, `ets_clk` = 1.
- Request-to-`done` latency: between 1 and `PERIOD_CYCLES` cycles. It is exactly `PERIOD_CYCLES` when the request is accepted on a wrap edge.
- `phase_out` updates on the same edge as `done`.
- Reset asserted mid-request: the pending request is discarded, no `done` is produced, and all registers return to their reset values immediately (asynchronously).
- No combinational path from any input to any output.

## Test plan

1. `PERIOD_CYCLES`=8, `LOCK_PERIODS`=2, reset release, no requests.
   - `ref_clk` = 11110000 repeating from edge 1.
   - `ets_clk` identical to `ref_clk`.
   - `locked` rises at edge 9.
2. `load` with `delay_in`=4 while `cnt`=2.
   - `busy` high for 5 cycles; `done` pulses at the next wrap.
   - `phase_out` = 4; `ets_clk` = ~`ref_clk` thereafter.
3. `load` with `delay_in`=7 on a wrap edge.
   - `done` exactly 8 cycles later; `ets_clk` pattern relative to `cnt` 0..7 = 11100001.
4. `PERIOD_CYCLES`=6, `delay_in`=7.
   - Clamped: `phase_out` = 5 after `done`.
5. d = 7 (period 8), then `step_inc`: `phase_out` = 0.
   - Then `step_dec`: `phase_out` = 7.
   - `step_inc` + `step_dec` in the same cycle: `busy` stays 0, no `done`.
   - Second `load` while `busy`: ignored, exactly one `done`.
6. Assert `reset` while `busy`=1.
   - All outputs return to reset values immediately.
   - After release: no `done`, `phase_out` = 0, `locked` re-asserts after 2 wraps.

Source files
------------

// File: rtl/ets_phase_clkgen.sv
// -----------------------------------------------------------------------------
// ets_phase_clkgen
//
// Phase-offset clock generator for equivalent-time sampling. A free-running
// phase counter divides clk into a reference square wave (ref_clk) and a second
// square wave (ets_clk) that lags it by a programmable number of clk cycles.
// The lag is changed through a load/step handshake. A new lag is applied only
// at a period boundary (counter wrap), so ets_clk never produces a runt pulse.
//
// Parameters
//   PERIOD_CYCLES  clk cycles per output period (even, >= 4)
//   DELAY_WIDTH    width of the phase code
//   LOCK_PERIODS   wraps after reset before locked asserts (>= 1)
//
// Ports
//   clk        in   system clock, rising-edge logic
//   reset      in   asynchronous active-high reset
//   delay_in   in   absolute lag for a load request
//   load       in   one-cycle request to apply delay_in
//   step_inc   in   one-cycle request for lag + 1 (modulo period)
//   step_dec   in   one-cycle request for lag - 1 (modulo period)
//   busy       out  a request is accepted and waiting for the next wrap
//   done       out  one-cycle pulse on the edge the new lag takes effect
//   phase_out  out  currently active lag
//   ref_clk    out  divided reference square wave
//   ets_clk    out  phase-lagged square wave
//   locked     out  outputs stable after reset
// -----------------------------------------------------------------------------
module ets_phase_clkgen #(
  parameter int PERIOD_CYCLES = 256,
  parameter int DELAY_WIDTH   = $clog2(PERIOD_CYCLES),
  parameter int LOCK_PERIODS  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DELAY_WIDTH-1:0] delay_in,
  input  logic                   load,
  input  logic                   step_inc,
  input  logic                   step_dec,
  output logic                   busy,
  output logic                   done,
  output logic [DELAY_WIDTH-1:0] phase_out,
  output logic                   ref_clk,
  output logic                   ets_clk,
  output logic                   locked
);

  // Width of the saturating wrap counter used for lock detection.
  localparam int LOCK_W = $clog2(LOCK_PERIODS + 1);

  localparam logic [DELAY_WIDTH-1:0] ZERO_D   = {DELAY_WIDTH{1'b0}};
  localparam logic [DELAY_WIDTH-1:0] ONE_D    = DELAY_WIDTH'(1);
  localparam logic [DELAY_WIDTH-1:0] LAST_D   = DELAY_WIDTH'(PERIOD_CYCLES - 1);
  // Wide (DELAY_WIDTH+1) constants for the modulo lag arithmetic and compares.
  localparam logic [DELAY_WIDTH:0]   PERIOD_W = (DELAY_WIDTH + 1)'(PERIOD_CYCLES);
  localparam logic [DELAY_WIDTH:0]   HALF_W   = (DELAY_WIDTH + 1)'(PERIOD_CYCLES / 2);
  localparam logic [LOCK_W-1:0]      LOCK_TGT = LOCK_W'(LOCK_PERIODS);
  localparam logic [LOCK_W-1:0]      LOCK_ONE = LOCK_W'(1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  // Registered state
  state_t                 state;
  logic [DELAY_WIDTH-1:0] cnt;
  logic [DELAY_WIDTH-1:0] pending;
  logic [LOCK_W-1:0]      wrap_cnt;

  // Next-state values
  state_t                 state_next;
  logic [DELAY_WIDTH-1:0] cnt_next;
  logic [DELAY_WIDTH-1:0] pending_next;
  logic [DELAY_WIDTH-1:0] phase_next;
  logic                   done_next;
  logic [LOCK_W-1:0]      wrap_cnt_next;
  logic                   locked_next;
  logic                   ref_next;
  logic                   ets_next;

  // Decoded request and helpers
  logic                   wrap;
  logic                   req_valid;
  logic [DELAY_WIDTH-1:0] req_value;
  logic [DELAY_WIDTH:0]   cnt_w;
  logic [DELAY_WIDTH:0]   phase_w;
  logic [DELAY_WIDTH:0]   lag_pos;

  // Phase counter: counts 0..PERIOD_CYCLES-1; the edge leaving LAST_D is a wrap.
  always_comb begin
    wrap = (cnt == LAST_D);
    if (wrap) begin
      cnt_next = ZERO_D;
    end else begin
      cnt_next = cnt + ONE_D;
    end
  end

  // Request decode: load beats a single step; simultaneous inc+dec is ignored.
  // The load value is compared wide so the clamp also works when the code
  // space exceeds the period (non-power-of-two periods).
  always_comb begin
    req_valid = 1'b0;
    req_value = phase_out;
    if (load) begin
      req_valid = 1'b1;
      if ({1'b0, delay_in} >= PERIOD_W) begin
        req_value = LAST_D;
      end else begin
        req_value = delay_in;
      end
    end else if (step_inc && !step_dec) begin
      req_valid = 1'b1;
      if (phase_out == LAST_D) begin
        req_value = ZERO_D;
      end else begin
        req_value = phase_out + ONE_D;
      end
    end else if (step_dec && !step_inc) begin
      req_valid = 1'b1;
      if (phase_out == ZERO_D) begin
        req_value = LAST_D;
      end else begin
        req_value = phase_out - ONE_D;
      end
    end else begin
      req_valid = 1'b0;
      req_value = phase_out;
    end
  end

  // Handshake FSM: IDLE accepts a request; PEND holds it until the next wrap.
  // A request accepted on a wrap edge enters PEND after that wrap, so it is
  // applied one full period later.
  always_comb begin
    state_next   = state;
    pending_next = pending;
    phase_next   = phase_out;
    done_next    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          state_next   = ST_PEND;
          pending_next = req_value;
        end else begin
          state_next   = ST_IDLE;
        end
      end
      ST_PEND: begin
        if (wrap) begin
          state_next = ST_IDLE;
          phase_next = pending;
          done_next  = 1'b1;
        end else begin
          state_next = ST_PEND;
        end
      end
      default: begin
        state_next   = ST_IDLE;
        pending_next = ZERO_D;
        phase_next   = ZERO_D;
        done_next    = 1'b0;
      end
    endcase
  end

  // Output waveform: uses next count and next lag so that on the applying edge
  // ets_clk already reflects the new phase. The lag subtraction is one bit
  // wider than the code and adds the period back when it would go negative.
  always_comb begin
    cnt_w   = {1'b0, cnt_next};
    phase_w = {1'b0, phase_next};
    if (cnt_w >= phase_w) begin
      lag_pos = cnt_w - phase_w;
    end else begin
      lag_pos = (cnt_w + PERIOD_W) - phase_w;
    end
    ref_next = (cnt_w < HALF_W);
    ets_next = (lag_pos < HALF_W);
  end

  // Lock detection: saturating count of wraps since reset; the first edge
  // after reset is a wrap because the counter resets to LAST_D.
  always_comb begin
    if (wrap && (wrap_cnt != LOCK_TGT)) begin
      wrap_cnt_next = wrap_cnt + LOCK_ONE;
    end else begin
      wrap_cnt_next = wrap_cnt;
    end
    locked_next = (wrap_cnt_next == LOCK_TGT);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= LAST_D;
      pending   <= ZERO_D;
      wrap_cnt  <= {LOCK_W{1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
      phase_out <= ZERO_D;
      ref_clk   <= 1'b0;
      ets_clk   <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      pending   <= pending_next;
      wrap_cnt  <= wrap_cnt_next;
      busy      <= (state_next == ST_PEND);
      done      <= done_next;
      phase_out <= phase_next;
      ref_clk   <= ref_next;
      ets_clk   <= ets_next;
      locked    <= locked_next;
    end
  end

endmodule

// File: tb/tb_ets_phase_clkgen.sv
// -----------------------------------------------------------------------------
// tb_ets_phase_clkgen
//
// Directed bench for ets_phase_clkgen. One instance runs with an 8-cycle
// period and one with a 6-cycle period to exercise the clamp and the modulo
// arithmetic for non-power-of-two periods. Inputs are driven 1 time unit after
// the rising edge, and outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_ets_phase_clkgen;

  localparam int P  = 8;
  localparam int P6 = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] delay_in;
  logic       load, step_inc, step_dec;
  logic       busy, done, ref_clk, ets_clk, locked;
  logic [2:0] phase_out;

  logic [2:0] delay6;
  logic       load6;
  logic       busy6, done6, ref6, ets6, locked6;
  logic [2:0] phase6;

  int n_checks = 0;
  int n_pass   = 0;
  int k        = P - 1;  // bench copy of the 8-cycle phase counter
  int lat;
  int ndone;
  int busy_cycles;
  int found;
  logic [7:0] pat;

  always #5 clk = ~clk;

  ets_phase_clkgen #(.PERIOD_CYCLES(P), .DELAY_WIDTH(3), .LOCK_PERIODS(2)) dut (
    .clk(clk), .reset(reset), .delay_in(delay_in), .load(load),
    .step_inc(step_inc), .step_dec(step_dec), .busy(busy), .done(done),
    .phase_out(phase_out), .ref_clk(ref_clk), .ets_clk(ets_clk), .locked(locked)
  );

  ets_phase_clkgen #(.PERIOD_CYCLES(P6), .DELAY_WIDTH(3), .LOCK_PERIODS(2)) dut6 (
    .clk(clk), .reset(reset), .delay_in(delay6), .load(load6),
    .step_inc(1'b0), .step_dec(1'b0), .busy(busy6), .done(done6),
    .phase_out(phase6), .ref_clk(ref6), .ets_clk(ets6), .locked(locked6)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int exp_ref(input int kk);
    return (kk < P / 2) ? 1 : 0;
  endfunction

  function automatic int exp_ets(input int kk, input int dd);
    return ((((kk - dd) + P) % P) < P / 2) ? 1 : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    k = (k + 1) % P;
  endtask

  task automatic pulse(input logic l, input logic [2:0] dv, input logic inc, input logic dec);
    load = l; delay_in = dv; step_inc = inc; step_dec = dec;
    tick();
    load = 1'b0; step_inc = 1'b0; step_dec = 1'b0;
  endtask

  task automatic wait_done(output int lat_o);
    lat_o = -1;
    for (int i = 1; i <= 2 * P; i++) begin
      tick();
      if (done) begin
        lat_o = i;
        break;
      end
    end
  endtask

  task automatic run_check(input int n, input int dd, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      check({tag, "_ref"}, ref_clk, exp_ref(k));
      check({tag, "_ets"}, ets_clk, exp_ets(k, dd));
      check({tag, "_done"}, done, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; delay_in = 3'd0; load = 1'b0; step_inc = 1'b0; step_dec = 1'b0;
    delay6 = 3'd0; load6 = 1'b0;
    @(posedge clk);
    #1;
    check("rst_ref", ref_clk, 0);
    check("rst_ets", ets_clk, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_phase", phase_out, 0);
    check("rst_locked", locked, 0);

    // 1: free run, no requests
    @(negedge clk);
    reset = 1'b0;
    k = P - 1;
    for (int e = 1; e <= 16; e++) begin
      tick();
      check("t1_ref", ref_clk, exp_ref(k));
      check("t1_ets", ets_clk, exp_ets(k, 0));
      check("t1_locked", locked, (e >= 9) ? 1 : 0);
    end

    // 2: load 4 sampled while cnt = 2
    repeat (3) tick();
    check("t2_cnt_model", k, 2);
    pulse(1'b1, 3'd4, 1'b0, 1'b0);
    busy_cycles = busy ? 1 : 0;
    check("t2_done_early", done, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (busy) busy_cycles++;
    end
    tick();
    check("t2_busy_cycles", busy_cycles, 5);
    check("t2_done", done, 1);
    check("t2_busy_clr", busy, 0);
    check("t2_phase", phase_out, 4);
    check("t2_ref_at_done", ref_clk, 1);
    check("t2_ets_at_done", ets_clk, 0);
    run_check(7, 4, "t2_run");

    // 3: load 7 on a wrap edge
    pulse(1'b1, 3'd7, 1'b0, 1'b0);
    wait_done(lat);
    check("t3_latency", lat, 8);
    check("t3_phase", phase_out, 7);
    pat[7] = ets_clk;
    for (int i = 1; i < 8; i++) begin
      tick();
      pat[7 - i] = ets_clk;
    end
    check("t3_pattern", pat, 8'b11100001);

    // 5: step wrap-around, both steps, drop while busy
    pulse(1'b0, 3'd0, 1'b1, 1'b0);
    wait_done(lat);
    check("t5_inc_latency", lat, 8);
    check("t5_inc_phase", phase_out, 0);
    pulse(1'b0, 3'd0, 1'b0, 1'b1);
    wait_done(lat);
    check("t5_dec_latency", lat, 7);
    check("t5_dec_phase", phase_out, 7);
    pulse(1'b0, 3'd0, 1'b1, 1'b1);
    check("t5_both_busy", busy, 0);
    ndone = 0;
    for (int i = 0; i < 2 * P; i++) begin
      tick();
      if (done) ndone++;
    end
    check("t5_both_ndone", ndone, 0);
    check("t5_both_phase", phase_out, 7);
    pulse(1'b1, 3'd2, 1'b0, 1'b0);
    check("t5_busy_first", busy, 1);
    pulse(1'b1, 3'd5, 1'b0, 1'b0);
    ndone = 0;
    for (int i = 0; i < 2 * P; i++) begin
      tick();
      if (done) ndone++;
    end
    check("t5_drop_ndone", ndone, 1);
    check("t5_drop_phase", phase_out, 2);

    // 4: period 6, load 7 is clamped to 5; modulo lag check
    load6 = 1'b1; delay6 = 3'd7;
    tick();
    load6 = 1'b0;
    check("t4_busy6", busy6, 1);
    found = 0;
    for (int i = 0; i < 2 * P6; i++) begin
      if (found == 0) begin
        tick();
        if (done6) found = 1;
      end
    end
    check("t4_done6_seen", found, 1);
    check("t4_phase6", phase6, 5);
    check("t4_ref6_k0", ref6, 1);
    check("t4_ets6_k0", ets6, 1);
    tick();
    tick();
    check("t4_ref6_k2", ref6, 1);
    check("t4_ets6_k2", ets6, 0);
    tick();
    tick();
    tick();
    check("t4_ref6_k5", ref6, 0);
    check("t4_ets6_k5", ets6, 1);

    // 6: reset while busy
    pulse(1'b1, 3'd3, 1'b0, 1'b0);
    check("t6_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("t6_async_busy", busy, 0);
    check("t6_async_done", done, 0);
    check("t6_async_phase", phase_out, 0);
    check("t6_async_ref", ref_clk, 0);
    check("t6_async_ets", ets_clk, 0);
    check("t6_async_locked", locked, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    k = P - 1;
    ndone = 0;
    for (int e = 1; e <= 16; e++) begin
      tick();
      if (done) ndone++;
      if (e == 1) check("t6_ref_e1", ref_clk, 1);
      if (e == 8) check("t6_locked_e8", locked, 0);
      if (e == 9) check("t6_locked_e9", locked, 1);
    end
    check("t6_ndone", ndone, 0);
    check("t6_phase", phase_out, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
